rtc_uart_time_tx: RTL and testbench



---
 rtl/rtc_uart_pkg.sv | 20 ++
 rtl/bcd2ascii.sv | 18 +
 rtl/rtc_uart_time_tx.sv | 187 ++++++++++++++++++
 tb/tb_rtc_uart_time_tx.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_uart_pkg.sv
// rtl/rtc_uart_pkg.sv - shared state encoding and ASCII/frame constants for the RTC time printer
package rtc_uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_QMARK = 8'h3F;

    localparam int FRAME_LEN_CRLF = 10;
    localparam int FRAME_LEN_BARE = 8;

endpackage

// File: rtl/bcd2ascii.sv
// rtl/bcd2ascii.sv - BCD nibble to ASCII digit, invalid nibbles become '?'
module bcd2ascii
    import rtc_uart_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    // digits 0..9 map onto '0'..'9'; A..F cannot be a time digit, so flag them visibly
    always_comb begin
        if (nibble <= 4'd9) begin
            ascii = ASCII_ZERO + {4'd0, nibble};
        end else begin
            ascii = ASCII_QMARK;
        end
    end

endmodule

// File: rtl/rtc_uart_time_tx.sv
// rtl/rtc_uart_time_tx.sv - sequences "HH:MM:SS\r\n" into the single-byte UART transmitter
module rtc_uart_time_tx
    import rtc_uart_pkg::*;
#(
    parameter int TERM_CRLF      = 1,
    parameter int GAP_CYCLES     = 0,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start,
    input  logic [7:0] hour_bcd,
    input  logic [7:0] min_bcd,
    input  logic [7:0] sec_bcd,
    input  logic       tx_done,
    input  logic       tx_busy,
    output logic       send_en,
    output logic [7:0] tx_data,
    output logic       busy,
    output logic       frame_done,
    output logic       frame_err
);

    localparam logic [3:0]  LAST     = (TERM_CRLF != 0) ? 4'(FRAME_LEN_CRLF - 1)
                                                        : 4'(FRAME_LEN_BARE - 1);
    localparam logic [15:0] GAP_LAST = (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;
    localparam logic [31:0] TO_LAST  = 32'(TIMEOUT_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  idx;
    logic [15:0] gap_cnt;
    logic [31:0] to_cnt;
    logic        pending;
    logic [7:0]  hour_r;
    logic [7:0]  min_r;
    logic [7:0]  sec_r;

    logic        is_last;
    logic        restart;
    logic        timeout_hit;
    logic        load_byte;
    logic [3:0]  ld_idx;
    logic [7:0]  src_h;
    logic [7:0]  src_m;
    logic [7:0]  src_s;
    logic [3:0]  nib;
    logic [7:0]  digit;
    logic [7:0]  ld_byte;

    assign is_last     = (idx == LAST);
    // a frame (re)starts from IDLE, or back-to-back when a request was queued or arrives with the last tx_done
    assign restart     = ((state == ST_IDLE) && start)
                      || ((state == ST_WAIT) && tx_done && is_last && (pending || start));
    assign timeout_hit = (state == ST_WAIT) && !tx_done && (to_cnt == TO_LAST);
    // tx_data is loaded on entry to ISSUE so it is valid the same cycle send_en rises
    assign load_byte   = (state_nxt == ST_ISSUE) && (state != ST_ISSUE);

    // state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state decision
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (!tx_busy) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (tx_done) begin
                    if (is_last) begin
                        state_nxt = restart ? ST_ISSUE : ST_IDLE;
                    end else begin
                        state_nxt = (GAP_CYCLES > 0) ? ST_GAP : ST_ISSUE;
                    end
                end else if (timeout_hit) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) state_nxt = ST_ISSUE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // decoded outputs
    always_comb begin
        send_en    = (state == ST_ISSUE) && !tx_busy;
        busy       = (state != ST_IDLE);
        frame_done = (state == ST_WAIT) && tx_done && is_last;
        frame_err  = timeout_hit;
    end

    // pick the byte index and time source for the byte about to be presented
    always_comb begin
        ld_idx = idx;
        if (restart) begin
            ld_idx = 4'd0;
        end else if (state == ST_WAIT) begin
            ld_idx = idx + 4'd1;
        end
        src_h = restart ? hour_bcd : hour_r;
        src_m = restart ? min_bcd  : min_r;
        src_s = restart ? sec_bcd  : sec_r;
        case (ld_idx)
            4'd0:    nib = src_h[7:4];
            4'd1:    nib = src_h[3:0];
            4'd3:    nib = src_m[7:4];
            4'd4:    nib = src_m[3:0];
            4'd6:    nib = src_s[7:4];
            4'd7:    nib = src_s[3:0];
            default: nib = 4'd0;
        endcase
    end

    bcd2ascii u_digit (
        .nibble (nib),
        .ascii  (digit)
    );

    // separators and line ending are fixed characters, everything else is a digit
    always_comb begin
        case (ld_idx)
            4'd2, 4'd5: ld_byte = ASCII_COLON;
            4'd8:       ld_byte = ASCII_CR;
            4'd9:       ld_byte = ASCII_LF;
            default:    ld_byte = digit;
        endcase
    end

    // snapshot, byte index, counters, pending request and output byte
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx     <= 4'd0;
            gap_cnt <= 16'd0;
            to_cnt  <= 32'd0;
            pending <= 1'b0;
            hour_r  <= 8'd0;
            min_r   <= 8'd0;
            sec_r   <= 8'd0;
            tx_data <= 8'd0;
        end else begin
            if (restart) begin
                hour_r <= hour_bcd;
                min_r  <= min_bcd;
                sec_r  <= sec_bcd;
                idx    <= 4'd0;
            end else if ((state == ST_WAIT) && tx_done) begin
                idx <= is_last ? 4'd0 : idx + 4'd1;
            end

            if ((state == ST_ISSUE) && !tx_busy) begin
                to_cnt <= 32'd0;
            end else if (state == ST_WAIT) begin
                to_cnt <= to_cnt + 32'd1;
            end

            if ((state == ST_WAIT) && tx_done) begin
                gap_cnt <= 16'd0;
            end else if (state == ST_GAP) begin
                gap_cnt <= gap_cnt + 16'd1;
            end

            // one-deep request queue; an aborted frame drops any queued request
            if (restart || timeout_hit) begin
                pending <= 1'b0;
            end else if (start && (state != ST_IDLE)) begin
                pending <= 1'b1;
            end

            if (load_byte) begin
                tx_data <= ld_byte;
            end
        end
    end

endmodule

// File: tb/tb_rtc_uart_time_tx.sv
// tb/tb_rtc_uart_time_tx.sv - scoreboard bench for rtc_uart_time_tx
module tb_rtc_uart_time_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn;
    logic       start_a, tx_busy_a, send_en_a, busy_a, frame_done_a, frame_err_a;
    logic       tx_done_a = 1'b0;
    logic [7:0] hour_a, min_a, sec_a, tx_data_a;
    logic       start_b, tx_busy_b, send_en_b, busy_b, frame_done_b, frame_err_b;
    logic       tx_done_b = 1'b0;
    logic [7:0] hour_b, min_b, sec_b, tx_data_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int sends_a = 0, fd_a = 0, fe_a = 0, hold_a = -1, cnt_a = 0, fe_cyc_a = 0, send_cyc_a = 0;
    int sends_b = 0, fd_b = 0, cnt_b = 0, done_cyc_b = -1;
    bit [7:0] q_a[$];
    bit [7:0] q_b[$];

    rtc_uart_time_tx #(.TERM_CRLF(1), .GAP_CYCLES(0), .TIMEOUT_CYCLES(100)) dut_a (
        .clk(clk), .rstn(rstn), .start(start_a),
        .hour_bcd(hour_a), .min_bcd(min_a), .sec_bcd(sec_a),
        .tx_done(tx_done_a), .tx_busy(tx_busy_a),
        .send_en(send_en_a), .tx_data(tx_data_a), .busy(busy_a),
        .frame_done(frame_done_a), .frame_err(frame_err_a)
    );

    rtc_uart_time_tx #(.TERM_CRLF(0), .GAP_CYCLES(5), .TIMEOUT_CYCLES(100)) dut_b (
        .clk(clk), .rstn(rstn), .start(start_b),
        .hour_bcd(hour_b), .min_bcd(min_b), .sec_bcd(sec_b),
        .tx_done(tx_done_b), .tx_busy(tx_busy_b),
        .send_en(send_en_b), .tx_data(tx_data_b), .busy(busy_b),
        .frame_done(frame_done_b), .frame_err(frame_err_b)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit [7:0] dig(input bit [3:0] n);
        return (n <= 4'd9) ? (8'h30 + {4'h0, n}) : 8'h3F;
    endfunction

    task automatic push_frame(input bit sel_b, input bit [7:0] h, input bit [7:0] m,
                              input bit [7:0] s, input bit crlf);
        bit [7:0] f[10];
        f = '{dig(h[7:4]), dig(h[3:0]), 8'h3A, dig(m[7:4]), dig(m[3:0]), 8'h3A,
              dig(s[7:4]), dig(s[3:0]), 8'h0D, 8'h0A};
        for (int i = 0; i < (crlf ? 10 : 8); i++) begin
            if (sel_b) q_b.push_back(f[i]);
            else       q_a.push_back(f[i]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fd(input bit sel_b, input int target, input int max, input string tag);
        int n = 0;
        while (((sel_b ? fd_b : fd_a) < target) && (n < max)) begin
            @(posedge clk);
            n++;
        end
        chk(tag, sel_b ? fd_b : fd_a, target);
    endtask

    always @(posedge clk) cyc++;

    // byte transmitter model: tx_done three cycles after each send_en unless withheld
    always @(posedge clk) begin
        #1;
        tx_done_a = 1'b0;
        if (cnt_a > 0) begin
            cnt_a--;
            if (cnt_a == 0) tx_done_a = 1'b1;
        end
        tx_done_b = 1'b0;
        if (cnt_b > 0) begin
            cnt_b--;
            if (cnt_b == 0) tx_done_b = 1'b1;
        end
    end

    // scoreboard monitor for dut_a
    always @(negedge clk) begin
        if (rstn) begin
            if (send_en_a) begin
                sends_a++;
                send_cyc_a = cyc;
                chk("a_send_expected", (q_a.size() != 0) ? 1 : 0, 1);
                if (q_a.size() != 0) chk("a_tx_data", tx_data_a, q_a.pop_front());
                if (sends_a != hold_a) cnt_a = 3;
            end
            if (frame_done_a) fd_a++;
            if (frame_err_a) begin
                fe_a++;
                fe_cyc_a = cyc;
            end
            if (frame_done_a || frame_err_a) chk("a_done_err_excl", frame_done_a && frame_err_a, 0);
        end
    end

    // scoreboard monitor for dut_b, including the inter-byte gap
    always @(negedge clk) begin
        if (rstn) begin
            if (send_en_b) begin
                sends_b++;
                chk("b_send_expected", (q_b.size() != 0) ? 1 : 0, 1);
                if (q_b.size() != 0) chk("b_tx_data", tx_data_b, q_b.pop_front());
                if (done_cyc_b >= 0) chk("b_gap", cyc - done_cyc_b, 6);
                cnt_b = 3;
            end
            if (tx_done_b && busy_b) done_cyc_b = cyc;
            if (frame_done_b) begin
                fd_b++;
                done_cyc_b = -1;
            end
            if (frame_err_b) chk("b_frame_err", 1, 0);
        end
    end

    initial begin
        int s0, f0, e0;
        rstn = 1'b0;
        start_a = 0; tx_busy_a = 0; hour_a = 0; min_a = 0; sec_a = 0;
        start_b = 0; tx_busy_b = 0; hour_b = 0; min_b = 0; sec_b = 0;
        repeat (3) tick();
        chk("rst_send_en", send_en_a, 0);
        chk("rst_tx_data", tx_data_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_frame_done", frame_done_a, 0);
        chk("rst_frame_err", frame_err_a, 0);
        chk("rst_b_busy", busy_b, 0);
        rstn = 1'b1;
        repeat (2) tick();

        // 12:34:56 with CR/LF, no gap
        hour_a = 8'h12; min_a = 8'h34; sec_a = 8'h56;
        push_frame(0, 8'h12, 8'h34, 8'h56, 1);
        s0 = sends_a; f0 = fd_a;
        start_a = 1; tick(); start_a = 0;
        @(negedge clk);
        chk("a_start_latency", send_en_a, 1);
        wait_fd(0, f0 + 1, 200, "a_frame1_done");
        repeat (2) tick();
        @(negedge clk);
        chk("a_frame1_sends", sends_a - s0, 10);
        chk("a_frame1_busy_low", busy_a, 0);
        chk("a_frame1_queue", q_a.size(), 0);

        // 8-byte frame with 5-cycle gaps
        hour_b = 8'h12; min_b = 8'h34; sec_b = 8'h56;
        push_frame(1, 8'h12, 8'h34, 8'h56, 0);
        s0 = sends_b;
        start_b = 1; tick(); start_b = 0;
        wait_fd(1, 1, 300, "b_frame_done");
        repeat (2) tick();
        chk("b_sends", sends_b - s0, 8);
        chk("b_busy_low", busy_b, 0);
        chk("b_queue", q_b.size(), 0);

        // invalid BCD hour units digit
        hour_a = 8'h1A;
        push_frame(0, 8'h1A, 8'h34, 8'h56, 1);
        s0 = sends_a; f0 = fd_a;
        start_a = 1; tick(); start_a = 0;
        wait_fd(0, f0 + 1, 200, "a_badbcd_done");
        repeat (2) tick();
        chk("a_badbcd_sends", sends_a - s0, 10);

        // transmitter busy holds off the first byte
        hour_a = 8'h12;
        push_frame(0, 8'h12, 8'h34, 8'h56, 1);
        s0 = sends_a; f0 = fd_a;
        tx_busy_a = 1;
        start_a = 1; tick(); start_a = 0;
        repeat (20) tick();
        chk("a_stall_no_send", sends_a - s0, 0);
        chk("a_stall_busy", busy_a, 1);
        tx_busy_a = 0;
        @(negedge clk);
        chk("a_stall_release", send_en_a, 1);
        wait_fd(0, f0 + 1, 200, "a_stall_done");
        repeat (2) tick();

        // queued restarts and mid-frame input change
        push_frame(0, 8'h12, 8'h34, 8'h56, 1);
        push_frame(0, 8'h23, 8'h59, 8'h59, 1);
        s0 = sends_a; f0 = fd_a;
        start_a = 1; tick(); start_a = 0;
        repeat (5) tick();
        start_a = 1; tick(); start_a = 0;
        repeat (5) tick();
        start_a = 1; tick(); start_a = 0;
        hour_a = 8'h23; min_a = 8'h59; sec_a = 8'h59;
        wait_fd(0, f0 + 2, 400, "a_pending_done");
        repeat (30) tick();
        chk("a_pending_sends", sends_a - s0, 20);
        chk("a_pending_frames", fd_a - f0, 2);
        chk("a_pending_busy", busy_a, 0);
        chk("a_pending_queue", q_a.size(), 0);

        // timeout after the fourth byte is never acknowledged
        hour_a = 8'h12; min_a = 8'h34; sec_a = 8'h56;
        push_frame(0, 8'h12, 8'h34, 8'h56, 1);
        repeat (6) void'(q_a.pop_back());
        s0 = sends_a; f0 = fd_a; e0 = fe_a;
        hold_a = sends_a + 4;
        start_a = 1; tick(); start_a = 0;
        begin
            int n = 0;
            while ((fe_a == e0) && (n < 300)) begin
                @(posedge clk);
                n++;
            end
        end
        chk("a_timeout_err", fe_a - e0, 1);
        chk("a_timeout_latency", fe_cyc_a - send_cyc_a, 100);
        @(negedge clk);
        chk("a_timeout_busy", busy_a, 0);
        repeat (20) tick();
        chk("a_timeout_sends", sends_a - s0, 4);
        chk("a_timeout_no_done", fd_a - f0, 0);
        hold_a = -1;

        // asynchronous reset while the second byte is being launched
        push_frame(0, 8'h12, 8'h34, 8'h56, 1);
        repeat (8) void'(q_a.pop_back());
        s0 = sends_a;
        start_a = 1; tick(); start_a = 0;
        begin
            int n = 0;
            while ((sends_a < s0 + 1) && (n < 50)) begin
                @(posedge clk);
                n++;
            end
            n = 0;
            @(negedge clk);
            while (!send_en_a && (n < 50)) begin
                @(negedge clk);
                n++;
            end
        end
        chk("a_rst_pre_send", send_en_a, 1);
        #1;
        rstn = 1'b0;
        #1;
        chk("a_rst_send_en", send_en_a, 0);
        chk("a_rst_tx_data", tx_data_a, 0);
        chk("a_rst_busy", busy_a, 0);
        chk("a_rst_frame_done", frame_done_a, 0);
        chk("a_rst_frame_err", frame_err_a, 0);
        cnt_a = 0;
        repeat (2) tick();
        rstn = 1'b1;
        repeat (10) tick();
        chk("a_rst_no_resume", busy_a, 0);
        chk("a_rst_sends", sends_a - s0, 2);
        chk("a_rst_queue", q_a.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
